// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared constants and types for the block-RAM FIFO controller.
// RAM_LAT is the fixed read latency of the simple-dual-port RAM beside the controller.
package bram_fifo_ctrl_pkg;

    localparam int unsigned RAM_LAT = 2;

    // One flag per RAM read stage: bit 0 = issued last cycle, bit RAM_LAT-1 = data on dataout now.
    typedef logic [RAM_LAT-1:0] rd_pipe_t;

    function automatic int unsigned ram_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/bram_fifo_ctrl_if.sv
// Write-side and read-side valid/ready streams of the block-RAM FIFO.
// master = producer/consumer environment, slave = the FIFO controller.
interface bram_fifo_ctrl_if #(
    parameter int unsigned DATA_W = 36
) ();

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );

endinterface

// File: rtl/bram_fifo_obuf.sv
// Small register FIFO that absorbs RAM read latency; entry 0 is always the head,
// so the head word and its valid flag come straight from registers.
module bram_fifo_obuf #(
    parameter int unsigned DATA_W = 36,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] head,
    output logic              head_valid
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [CNT_W-1:0]  wr_idx;
    logic              do_pop;
    logic              do_push;

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        do_pop  = 1'b0;
        do_push = 1'b0;
        wr_idx  = '0;
        if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_d[i] = '0;
            end
            count_d = '0;
        end else begin
            do_pop = pop && (count_q != '0);
            if (do_pop) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    mem_d[i] = mem_q[i + 1];
                end
                mem_d[DEPTH-1] = '0;
            end
            // A word popped this cycle frees the slot the pushed word lands in.
            wr_idx  = count_q - CNT_W'(do_pop);
            do_push = push && (wr_idx < CNT_W'(DEPTH));
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (do_push && (wr_idx == CNT_W'(i))) begin
                    mem_d[i] = push_data;
                end
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign head       = mem_q[0];
    assign head_valid = (count_q != '0);

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Streaming FIFO controller around a 2-cycle-latency simple-dual-port block RAM.
// Drives all RAM addresses/write enable and hides read latency behind a credit-managed buffer.
module bram_fifo_ctrl
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 36,
    parameter int unsigned OUT_BUF = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    bram_fifo_ctrl_if.slave   bus,
    output logic [ADDR_W+1:0] level,
    output logic [ADDR_W-1:0] ram_rdaddr,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_datain,
    input  logic [DATA_W-1:0] ram_dataout
);

    localparam int unsigned DEPTH  = ram_depth(ADDR_W);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned LVL_W  = ADDR_W + 2;
    localparam int unsigned OB_W   = $clog2(OUT_BUF + 1);
    localparam int unsigned CRED_W = OB_W + 2;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  ram_count_q, ram_count_d;
    rd_pipe_t          rd_pipe_q, rd_pipe_d;
    logic              wr_stalled_q, wr_stalled_d;

    logic              wr_ok;
    logic              wr_fire;
    logic              rd_issue;
    logic [CRED_W-1:0] credit_used;
    logic [OB_W-1:0]   ob_count;
    logic              ob_push;
    logic              ob_pop;

    // Data lands on dataout RAM_LAT cycles after issue; it must have been sampled with we = 0.
    assign ob_push = rd_pipe_q[RAM_LAT-1];
    assign ob_pop  = bus.rd_valid && bus.rd_ready && !flush;

    always_comb begin
        // Blocking writes while a read is in its sampling cycle keeps the RAM output register live.
        wr_ok = !reset && !flush && (ram_count_q < CNT_W'(DEPTH)) && !rd_pipe_q[0];
        wr_fire = bus.wr_valid && wr_ok;

        // Buffer slots are reserved for every read still in the RAM pipeline.
        credit_used = CRED_W'(ob_count) + CRED_W'($countones(rd_pipe_q));
        rd_issue = (ram_count_q != '0) && (credit_used < CRED_W'(OUT_BUF)) && !flush
                   && !(bus.wr_valid && wr_stalled_q);

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        ram_count_d  = ram_count_q;
        rd_pipe_d    = rd_pipe_q;
        wr_stalled_d = wr_stalled_q;
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            ram_count_d  = '0;
            rd_pipe_d    = '0;
            wr_stalled_d = 1'b0;
        end else begin
            wr_ptr_d     = wr_ptr_q + ADDR_W'(wr_fire);
            rd_ptr_d     = rd_ptr_q + ADDR_W'(rd_issue);
            ram_count_d  = ram_count_q + CNT_W'(wr_fire) - CNT_W'(rd_issue);
            rd_pipe_d    = {rd_pipe_q[RAM_LAT-2:0], rd_issue};
            // Remembering a p1-blocked write lets it win the next cycle against a new read.
            wr_stalled_d = bus.wr_valid && rd_pipe_q[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_count_q  <= '0;
            rd_pipe_q    <= '0;
            wr_stalled_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_count_q  <= ram_count_d;
            rd_pipe_q    <= rd_pipe_d;
            wr_stalled_q <= wr_stalled_d;
        end
    end

    bram_fifo_obuf #(
        .DATA_W (DATA_W),
        .DEPTH  (OUT_BUF)
    ) u_obuf (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push       (ob_push),
        .push_data  (ram_dataout),
        .pop        (ob_pop),
        .count      (ob_count),
        .head       (bus.rd_data),
        .head_valid (bus.rd_valid)
    );

    assign bus.wr_ready = wr_ok;
    assign ram_we       = wr_fire;
    assign ram_datain   = bus.wr_data;
    assign ram_wraddr   = wr_ptr_q;
    assign ram_rdaddr   = rd_ptr_q;
    assign level        = LVL_W'(ram_count_q) + LVL_W'($countones(rd_pipe_q)) + LVL_W'(ob_count);

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl: behavioural RAM beside the DUT, queue-based scoreboard,
// randomized streams, fill/flush/reset scenarios.
module tb_bram_fifo_ctrl;

    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned DATA_W  = 36;
    localparam int unsigned OUT_BUF = 4;
    localparam int unsigned DEPTH   = 512;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic [ADDR_W+1:0] level;
    logic [ADDR_W-1:0] ram_rdaddr;
    logic [ADDR_W-1:0] ram_wraddr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_datain;
    logic [DATA_W-1:0] ram_dataout;

    bram_fifo_ctrl_if #(.DATA_W(DATA_W)) bus ();

    bram_fifo_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .OUT_BUF (OUT_BUF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .bus         (bus),
        .level       (level),
        .ram_rdaddr  (ram_rdaddr),
        .ram_wraddr  (ram_wraddr),
        .ram_we      (ram_we),
        .ram_datain  (ram_datain),
        .ram_dataout (ram_dataout)
    );

    always #5 clk = ~clk;

    // RAM model: address registered, data registered a cycle later only when we = 0.
    logic [DATA_W-1:0] ram_mem [DEPTH];
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_dout_q;
    always_ff @(posedge clk) begin
        if (ram_we) ram_mem[ram_wraddr] <= ram_datain;
        ram_addr_q <= ram_rdaddr;
        if (!ram_we) ram_dout_q <= ram_mem[ram_addr_q];
    end
    assign ram_dataout = ram_dout_q;

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] exp_q [$];
    int held   = 0;
    int wr_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: words held must equal accepted minus delivered, in FIFO order.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_level", 64'(level), 64'd0);
            chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
            chk("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
            exp_q.delete();
            held   = 0;
            wr_cnt = 0;
        end else begin
            chk("level", 64'(level), 64'(held));
            if (flush) begin
                exp_q.delete();
                held   = 0;
                wr_cnt = 0;
            end else begin
                if (bus.rd_valid && bus.rd_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL rd_unexpected: got %0h required none", bus.rd_data);
                    end else begin
                        if (bus.rd_data !== exp_q[0]) begin
                            bad++;
                            $display("FAIL rd_data: got %0h required %0h", bus.rd_data, exp_q[0]);
                        end
                        void'(exp_q.pop_front());
                        held--;
                    end
                end
                if (bus.wr_valid && bus.wr_ready) begin
                    chk("ram_wraddr", 64'(ram_wraddr), 64'(wr_cnt % DEPTH));
                    chk("ram_we", 64'(ram_we), 64'd1);
                    exp_q.push_back(bus.wr_data);
                    held++;
                    wr_cnt++;
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] rnd_word();
        return {4'($urandom()), $urandom()};
    endfunction

    // Random stream of n words, then drain; reports accepted words and cycles wr_valid was high.
    task automatic stream(input int n, input int wr_pct, input int rd_pct, input int max_cyc,
                          input string tag, output int acc, output int vcyc);
        int cyc = 0;
        acc  = 0;
        vcyc = 0;
        bus.wr_valid = 1'b0;
        while ((acc < n || held > 0) && cyc < max_cyc) begin
            if (acc < n && !bus.wr_valid && ($urandom_range(99) < wr_pct)) begin
                bus.wr_valid = 1'b1;
                bus.wr_data  = rnd_word();
            end
            bus.rd_ready = ($urandom_range(99) < rd_pct);
            @(negedge clk);
            if (bus.wr_valid) vcyc++;
            if (bus.wr_valid && bus.wr_ready) acc++;
            @(posedge clk);
            #1;
            if (acc >= n || (bus.wr_valid && acc > 0 && ($urandom_range(99) >= wr_pct))) begin
                bus.wr_valid = 1'b0;
            end
            if (bus.wr_valid && $urandom_range(1) == 0) bus.wr_data = rnd_word();
            cyc++;
        end
        total++;
        if (cyc >= max_cyc) begin
            bad++;
            $display("FAIL %s_timeout: got %0d cycles required drain within %0d", tag, cyc, max_cyc);
        end
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
    endtask

    initial begin
        int acc;
        int vcyc;
        int idle;
        int cyc;
        bit found;

        reset        = 1'b1;
        flush        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
        reset = 1'b0;

        // Single word latency: accepted in cycle 0, visible in cycle 4.
        bus.wr_valid = 1'b1;
        bus.wr_data  = 36'h000000001;
        bus.rd_ready = 1'b1;
        @(negedge clk);
        chk("lat_wr_ready", 64'(bus.wr_ready), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) bus.wr_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("lat_rd_valid_c%0d", k), 64'(bus.rd_valid), (k == 4) ? 64'd1 : 64'd0);
            if (k == 4) chk("lat_rd_data", 64'(bus.rd_data), 64'h000000001);
        end
        @(posedge clk);
        #1;
        bus.rd_ready = 1'b0;
        @(negedge clk);
        chk("lat_level_after", 64'(level), 64'd0);
        @(posedge clk);
        #1;

        // Full contention: writes must win at least half the cycles they are offered.
        stream(2000, 100, 100, 10000, "contend", acc, vcyc);
        chk("contend_count", 64'(acc), 64'd2000);
        chk("contend_fair", 64'(acc * 2 >= vcyc), 64'd1);

        // Mixed rates across several pointer wraps.
        stream(1500, 70, 50, 20000, "wrap", acc, vcyc);
        stream(600, 100, 30, 20000, "backpr", acc, vcyc);

        // Fill with no reader: RAM plus prefilled buffer.
        bus.rd_ready = 1'b0;
        bus.wr_valid = 1'b1;
        acc  = 0;
        idle = 0;
        cyc  = 0;
        bus.wr_data = 36'(acc);
        while (idle < 40 && cyc < 3000) begin
            @(negedge clk);
            if (bus.wr_ready) begin
                acc++;
                idle = 0;
            end else begin
                idle++;
            end
            @(posedge clk);
            #1;
            bus.wr_data = 36'(acc);
            cyc++;
        end
        bus.wr_valid = 1'b0;
        chk("fill_count", 64'(acc), 64'(DEPTH + OUT_BUF));
        @(negedge clk);
        chk("fill_level", 64'(level), 64'(DEPTH + OUT_BUF));
        chk("fill_wr_ready", 64'(bus.wr_ready), 64'd0);
        @(posedge clk);
        #1;
        stream(0, 0, 100, 3000, "fill_drain", acc, vcyc);

        // Flush with seven words held and reads in flight.
        bus.rd_ready = 1'b0;
        bus.wr_valid = 1'b1;
        acc = 0;
        cyc = 0;
        while (acc < 7 && cyc < 100) begin
            bus.wr_data = {4'h5, 32'(acc)};
            @(negedge clk);
            if (bus.wr_ready) acc++;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.wr_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_level_before", 64'(level), 64'd7);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_level_after", 64'(level), 64'd0);
        chk("flush_rd_valid", 64'(bus.rd_valid), 64'd0);
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 36'hABCDE0123;
        bus.rd_ready = 1'b1;
        @(negedge clk);
        chk("flush_wr_ready", 64'(bus.wr_ready), 64'd1);
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < 12) begin
            @(posedge clk);
            #1;
            bus.wr_valid = 1'b0;
            @(negedge clk);
            if (bus.rd_valid) begin
                found = 1'b1;
                chk("flush_first_word", 64'(bus.rd_data), 64'hABCDE0123);
            end
            cyc++;
        end
        chk("flush_word_seen", 64'(found), 64'd1);
        @(posedge clk);
        #1;
        bus.rd_ready = 1'b0;

        // Asynchronous reset in the middle of a busy stream.
        for (int k = 0; k < 30; k++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = rnd_word();
            bus.rd_ready = ($urandom_range(1) == 1);
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        chk("arst_rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("arst_level", 64'(level), 64'd0);
        chk("arst_wr_ready", 64'(bus.wr_ready), 64'd0);
        chk("arst_rd_data", 64'(bus.rd_data), 64'd0);
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        stream(300, 60, 60, 5000, "post_rst", acc, vcyc);
        chk("post_rst_count", 64'(acc), 64'd300);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
